// File: rtl/conv_pkg.sv
// conv_pkg: shared FSM state encoding and product/accumulator widths for conv3x3_s2
package conv_pkg;
  localparam int PROD_W = 16;
  localparam int ACC_W = 32;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
endpackage

// File: rtl/line_buffer.sv
// line_buffer: one row of DEPTH signed pixels; ports clk, en (write), addr, din, q (read-before-write of addr)
module line_buffer #(
  parameter int DEPTH = 128,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [AW-1:0]     addr,
  input  logic signed [7:0] din,
  output logic signed [7:0] q
);
  logic signed [7:0] mem [DEPTH];
  assign q = mem[addr];
  always_ff @(posedge clk) if (en) mem[addr] <= din;
endmodule

// File: rtl/conv3x3_s2.sv
// conv3x3_s2: 3x3 stride-2 unpadded conv; ports start/width/height frame ctl, w1..w9/bias kernel, in_* / out_* valid-ready streams, busy, frame_done
module conv3x3_s2
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH = 128,
  parameter int IMAGE_HEIGHT = 128
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [7:0]              width,
  input  logic [7:0]              height,
  input  logic signed [7:0]       w1,
  input  logic signed [7:0]       w2,
  input  logic signed [7:0]       w3,
  input  logic signed [7:0]       w4,
  input  logic signed [7:0]       w5,
  input  logic signed [7:0]       w6,
  input  logic signed [7:0]       w7,
  input  logic signed [7:0]       w8,
  input  logic signed [7:0]       w9,
  input  logic signed [7:0]       bias,
  input  logic signed [7:0]       in_pixel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [ACC_W-1:0] out_pixel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    frame_done
);
  localparam int AW = $clog2(IMAGE_WIDTH);
  state_t state, state_n;
  logic [7:0] w_r, h_r, col, row;
  logic signed [7:0] win [3][3];
  logic signed [7:0] nw [9];
  logic signed [7:0] wt [9];
  logic signed [PROD_W-1:0] prod [9];
  logic signed [PROD_W-1:0] s1_prod [9];
  logic signed [ACC_W-1:0] sum;
  logic signed [7:0] lb0_q, lb1_q;
  logic s1_valid, adv, accept, last_pix, win_ok, col_wrap;
  assign adv = !out_valid || out_ready;
  assign in_ready = state == RUN && adv;
  assign accept = in_valid && in_ready;
  assign col_wrap = col == w_r - 8'd1;
  assign last_pix = col_wrap && row == h_r - 8'd1;
  assign win_ok = row >= 8'd2 && col >= 8'd2 && !row[0] && !col[0];
  assign busy = state != IDLE;
  assign frame_done = state == DRAIN && !s1_valid && adv;
  assign wt = '{w1, w2, w3, w4, w5, w6, w7, w8, w9};
  // window after this accept: shift left, new right column = {row-2, row-1, current}
  assign nw = '{win[0][1], win[0][2], lb1_q, win[1][1], win[1][2], lb0_q, win[2][1], win[2][2], in_pixel};
  line_buffer #(.DEPTH(IMAGE_WIDTH), .AW(AW)) lb0 (
    .clk(clk), .en(accept), .addr(col[AW-1:0]), .din(in_pixel), .q(lb0_q)
  );
  line_buffer #(.DEPTH(IMAGE_WIDTH), .AW(AW)) lb1 (
    .clk(clk), .en(accept), .addr(col[AW-1:0]), .din(lb0_q), .q(lb1_q)
  );
  always_comb begin
    for (int i = 0; i < 9; i++) prod[i] = PROD_W'(wt[i]) * PROD_W'(nw[i]);
    sum = ACC_W'(bias);
    for (int i = 0; i < 9; i++) sum = sum + ACC_W'(s1_prod[i]);
  end
  always_comb begin
    state_n = state == IDLE ? (start ? RUN : IDLE)
            : state == RUN  ? (accept && last_pix ? DRAIN : RUN)
            : (frame_done ? IDLE : DRAIN);
  end
  always_ff @(posedge clk) begin
    if (accept)
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= nw[r*3+c];
    if (adv) s1_prod <= prod;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w_r <= '0;
      h_r <= '0;
      col <= '0;
      row <= '0;
      s1_valid <= 1'b0;
      out_valid <= 1'b0;
      out_pixel <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        w_r <= width;
        h_r <= height;
        col <= '0;
        row <= '0;
      end else if (accept) begin
        col <= col_wrap ? 8'd0 : col + 8'd1;
        row <= col_wrap ? row + 8'd1 : row;
      end
      if (adv) begin
        s1_valid <= accept && win_ok;
        out_valid <= s1_valid;
        if (s1_valid) out_pixel <= sum;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && state == IDLE && start)
      assert (32'(width) <= IMAGE_WIDTH && 32'(height) <= IMAGE_HEIGHT);
endmodule

// File: tb/tb_conv3x3_s2.sv
// tb_conv3x3_s2: directed self-checking bench for conv3x3_s2
module tb_conv3x3_s2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [7:0] width = '0, height = '0;
  logic signed [7:0] w1 = 0, w2 = 0, w3 = 0, w4 = 0, w5 = 0, w6 = 0, w7 = 0, w8 = 0, w9 = 0, bias = 0;
  logic signed [7:0] in_pixel = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, busy, frame_done;
  logic signed [31:0] out_pixel;
  int n_tests = 0, n_fail = 0, done_cnt = 0, acc_cnt = 0, cyc = 0, last_acc = 0, first_ov = -1, done_cyc = -1;
  logic signed [31:0] got [$];
  int exp_q [$];

  always #5 clk = ~clk;

  conv3x3_s2 dut (
    .clk(clk), .rst(rst), .start(start), .width(width), .height(height),
    .w1(w1), .w2(w2), .w3(w3), .w4(w4), .w5(w5), .w6(w6), .w7(w7), .w8(w8), .w9(w9),
    .bias(bias), .in_pixel(in_pixel), .in_valid(in_valid), .in_ready(in_ready),
    .out_pixel(out_pixel), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (!rst) begin
    if (in_valid && in_ready) begin acc_cnt++; last_acc = cyc; end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (out_valid && out_ready) got.push_back(out_pixel);
    if (frame_done) begin done_cnt++; if (done_cyc < 0) done_cyc = cyc; end
  end

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp_v);
    n_tests++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    end
  endtask

  task automatic check_outs(input string tag);
    check({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, i < got.size() ? got[i] : 32'hxxxxxxxx, exp_q[i]);
  endtask

  task automatic set_w(input logic signed [7:0] a, input logic signed [7:0] ctr, input logic signed [7:0] b);
    {w1, w2, w3, w4, w6, w7, w8, w9} = {8{a}};
    w5 = ctr;
    bias = b;
  endtask

  function automatic logic signed [7:0] pix(input int mode, input int r, input int c);
    return mode == 0 ? 8'sd1 : mode == 1 ? 8'(c) : mode == 2 ? 8'sd127 : 8'(r + c);
  endfunction

  task automatic push(input logic signed [7:0] p);
    int t = 0;
    in_pixel = p;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 1000) begin @(negedge clk); t++; end
    if (t >= 1000) check("push_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic feed(input int w, input int h, input int mode, input int n);
    int k = 0;
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        if (k < n) begin push(pix(mode, r, c)); k++; end
  endtask

  task automatic begin_frame(input int w, input int h);
    got.delete();
    done_cnt = 0; acc_cnt = 0; first_ov = -1; done_cyc = -1;
    width = 8'(w); height = 8'(h);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int t = 0;
    while (done_cnt == 0 && t < 2000) begin @(negedge clk); t++; end
    repeat (5) @(negedge clk);
    check({tag, "_done"}, done_cnt, 1);
    check({tag, "_busy"}, busy, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_out_pixel", out_pixel, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    set_w(1, 1, 0);
    begin_frame(5, 5);
    fork feed(5, 5, 0, 25); join_none
    wait_done("ones");
    exp_q = '{9, 9, 9, 9};
    check_outs("ones");

    set_w(0, 1, 3);
    begin_frame(5, 5);
    fork feed(5, 5, 1, 25); join_none
    wait_done("ramp");
    exp_q = '{4, 6, 4, 6};
    check_outs("ramp");

    set_w(-128, -128, -128);
    begin_frame(3, 3);
    fork feed(3, 3, 2, 9); join_none
    wait_done("extreme");
    exp_q = '{-146432};
    check_outs("extreme");
    check("latency", first_ov - last_acc, 2);

    set_w(1, 1, 0);
    out_ready = 1'b0;
    begin_frame(6, 6);
    fork feed(6, 6, 3, 36); join_none
    begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!out_valid && t < 500);
      check("stall_first", out_pixel, 18);
      repeat (10) begin
        @(negedge clk);
        check("stall_pixel", out_pixel, 18);
        check("stall_valid", out_valid, 1);
        check("stall_in_ready", in_ready, 0);
      end
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("stall");
    exp_q = '{18, 36, 36, 54};
    check_outs("stall");

    begin_frame(5, 5);
    feed(5, 5, 0, 12);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_done", done_cnt, 0);
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    begin_frame(5, 5);
    fork feed(5, 5, 0, 25); join_none
    wait_done("after_abort");
    exp_q = '{9, 9, 9, 9};
    check_outs("after_abort");

    begin_frame(2, 4);
    fork feed(2, 4, 0, 8); join_none
    wait_done("small");
    check("small_accepted", acc_cnt, 8);
    check("small_outputs", got.size(), 0);
    check("small_done_delay", done_cyc - last_acc, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
